// File: rtl/j_busarb_pkg.sv
// Shared types for the main-bus arbiter: owner codes, FSM states
// and the requester-bit mapping used by the mask register.
package j_busarb_pkg;

   typedef enum logic [1:0] {
      OWN_CPU = 2'd0,
      OWN_JHI = 2'd1,
      OWN_GPU = 2'd2,
      OWN_JLO = 2'd3
   } owner_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      TURN  = 2'd2,
      OWN   = 2'd3
   } state_e;

   localparam int NREQ = 3;

   // Request vector layout: bit0 Jerry-hi, bit1 GPU, bit2 Jerry-lo
   function automatic logic [NREQ-1:0] owner_bit(owner_e o);
      logic [NREQ-1:0] b;
      b = '0;
      unique case (o)
         OWN_JHI: b = 3'b001;
         OWN_GPU: b = 3'b010;
         OWN_JLO: b = 3'b100;
         default: b = 3'b000;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/j_busarb_prio.sv
// Fixed-priority picker: Jerry-hi over GPU over Jerry-lo,
// ignoring any requester whose mask bit is set.
module j_busarb_prio
   import j_busarb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [2:0] mask,
   output logic       valid,
   output logic [1:0] win
);

   logic [2:0] eff;

   assign eff = req & ~mask;

   always_comb begin
      valid = |eff;
      win   = OWN_CPU;
      if (eff[0])
         win = OWN_JHI;
      else if (eff[1])
         win = OWN_GPU;
      else if (eff[2])
         win = OWN_JLO;
   end

endmodule

// File: rtl/j_bus_arbiter.sv
// Main-bus arbiter: 68K default owner, Jerry/GPU alternates,
// idle-point handover with turnaround and a tenure watchdog.
module j_bus_arbiter
   import j_busarb_pkg::*;
#(
   parameter int TURN_CYC = 2,
   parameter int MAX_HOLD = 1024,
   parameter int HOLD_W   = $clog2(MAX_HOLD)
) (
   input  logic       sys_clk,
   input  logic       xresetil,
   input  logic       xdbrl_0,
   input  logic       xdbrl_1,
   input  logic       gpu_brl,
   input  logic       bus_idle,
   output logic       xdbgl,
   output logic       gpu_bgl,
   output logic       cpu_hold,
   output logic [1:0] owner,
   output logic       hold_err
);

   localparam int TW = (TURN_CYC < 2) ? 1 : $clog2(TURN_CYC + 1);
   localparam logic [TW-1:0]     TURN_LD   = TW'(TURN_CYC);
   localparam logic [TW-1:0]     TURN_ONE  = TW'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_e            state_q;
   owner_e            own_q;
   logic [TW-1:0]     turn_q;
   logic [HOLD_W-1:0] ten_q;
   logic [2:0]        mask_q;
   logic              rel_q;

   logic [2:0] req;
   logic       win_v;
   logic [1:0] win_c;
   owner_e     win_o;
   logic       own_req;
   logic       go_eval;

   assign req     = ~{xdbrl_0, gpu_brl, xdbrl_1};
   assign win_o   = owner_e'(win_c);
   assign own_req = |(req & owner_bit(own_q));
   assign owner   = own_q;

   j_busarb_prio u_prio (
      .req   (req),
      .mask  (mask_q),
      .valid (win_v),
      .win   (win_c)
   );

   // Grant decision point: end of pre-grant turnaround, or straight
   // out of DRAIN when no turnaround is configured.
   always_comb begin
      go_eval = 1'b0;
      if (state_q == DRAIN && bus_idle && TURN_CYC == 0)
         go_eval = 1'b1;
      if (state_q == TURN && !rel_q && turn_q <= TURN_ONE)
         go_eval = 1'b1;
   end

   always_ff @(posedge sys_clk or negedge xresetil) begin
      if (!xresetil) begin
         state_q  <= IDLE;
         own_q    <= OWN_CPU;
         turn_q   <= '0;
         ten_q    <= '0;
         mask_q   <= '0;
         rel_q    <= 1'b0;
         xdbgl    <= 1'b1;
         gpu_bgl  <= 1'b1;
         cpu_hold <= 1'b0;
         hold_err <= 1'b0;
      end else begin
         hold_err <= 1'b0;
         mask_q   <= mask_q & req;
         if (go_eval) begin
            if (win_v) begin
               state_q <= OWN;
               own_q   <= win_o;
               ten_q   <= '0;
               xdbgl   <= !(win_o == OWN_JHI || win_o == OWN_JLO);
               gpu_bgl <= !(win_o == OWN_GPU);
            end else begin
               state_q  <= IDLE;
               cpu_hold <= 1'b0;
            end
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (win_v) begin
                     state_q  <= DRAIN;
                     cpu_hold <= 1'b1;
                  end
               end
               DRAIN: begin
                  if (bus_idle) begin
                     state_q <= TURN;
                     turn_q  <= TURN_LD;
                     rel_q   <= 1'b0;
                  end
               end
               TURN: begin
                  if (turn_q <= TURN_ONE) begin
                     state_q  <= IDLE;
                     cpu_hold <= 1'b0;
                  end else begin
                     turn_q <= turn_q - TURN_ONE;
                  end
               end
               OWN: begin
                  if (!own_req || ten_q == HOLD_LAST) begin
                     xdbgl   <= 1'b1;
                     gpu_bgl <= 1'b1;
                     own_q   <= OWN_CPU;
                     // Watchdog: lock the hog out until it lets go
                     if (own_req) begin
                        hold_err <= 1'b1;
                        mask_q   <= (mask_q & req) | owner_bit(own_q);
                     end
                     if (TURN_CYC == 0) begin
                        state_q  <= IDLE;
                        cpu_hold <= 1'b0;
                     end else begin
                        state_q <= TURN;
                        turn_q  <= TURN_LD;
                        rel_q   <= 1'b1;
                     end
                  end else begin
                     ten_q <= ten_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_j_bus_arbiter.sv
// Directed vector bench for j_bus_arbiter (TURN_CYC=2, MAX_HOLD=8):
// a per-cycle table plus watchdog and async-reset sequences.
module tb_j_bus_arbiter;

   logic       sys_clk;
   logic       xresetil;
   logic       xdbrl_0;
   logic       xdbrl_1;
   logic       gpu_brl;
   logic       bus_idle;
   logic       xdbgl;
   logic       gpu_bgl;
   logic       cpu_hold;
   logic [1:0] owner;
   logic       hold_err;

   int tests;
   int fails;

   j_bus_arbiter #(
      .TURN_CYC (2),
      .MAX_HOLD (8)
   ) dut (
      .sys_clk  (sys_clk),
      .xresetil (xresetil),
      .xdbrl_0  (xdbrl_0),
      .xdbrl_1  (xdbrl_1),
      .gpu_brl  (gpu_brl),
      .bus_idle (bus_idle),
      .xdbgl    (xdbgl),
      .gpu_bgl  (gpu_bgl),
      .cpu_hold (cpu_hold),
      .owner    (owner),
      .hold_err (hold_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic       r0;
      logic       r1;
      logic       g;
      logic       bi;
      logic       xd;
      logic       gb;
      logic       h;
      logic [1:0] own;
      logic       err;
   } vec_t;

   localparam int NV = 54;
   vec_t vt[NV];

   function automatic vec_t mk(logic r0, logic r1, logic g, logic bi,
                               logic xd, logic gb, logic h,
                               logic [1:0] own, logic err);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.g = g; v.bi = bi;
      v.xd = xd; v.gb = gb; v.h = h; v.own = own; v.err = err;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs();
      return {26'd0, xdbgl, gpu_bgl, cpu_hold, owner, hold_err};
   endfunction

   // Advance one edge, sample 1ns later, check grant exclusivity
   task automatic step();
      int ok;
      @(posedge sys_clk);
      #1;
      ok = 1;
      if (!xdbgl && !gpu_bgl) ok = 0;
      if ((!xdbgl || !gpu_bgl) && !cpu_hold) ok = 0;
      chk("grant_excl", ok, 1);
   endtask

   initial begin
      int low, errs, grants, err_ok, n;
      logic prev;
      tests = 0;
      fails = 0;

      vt[0]  = mk(1,1,1,1, 1,1,0,0,0);
      vt[1]  = mk(1,0,1,1, 1,1,1,0,0);
      vt[2]  = mk(1,0,1,1, 1,1,1,0,0);
      vt[3]  = mk(1,0,1,1, 1,1,1,0,0);
      vt[4]  = mk(1,0,1,1, 0,1,1,1,0);
      vt[5]  = mk(1,0,1,1, 0,1,1,1,0);
      vt[6]  = mk(1,1,1,1, 1,1,1,0,0);
      vt[7]  = mk(1,1,1,1, 1,1,1,0,0);
      vt[8]  = mk(1,1,1,1, 1,1,0,0,0);
      vt[9]  = mk(1,1,1,1, 1,1,0,0,0);
      vt[10] = mk(0,1,0,1, 1,1,1,0,0);
      vt[11] = mk(0,1,0,1, 1,1,1,0,0);
      vt[12] = mk(0,1,0,1, 1,1,1,0,0);
      vt[13] = mk(0,1,0,1, 1,0,1,2,0);
      vt[14] = mk(0,1,1,1, 1,1,1,0,0);
      vt[15] = mk(0,1,1,1, 1,1,1,0,0);
      vt[16] = mk(0,1,1,1, 1,1,0,0,0);
      vt[17] = mk(0,1,1,1, 1,1,1,0,0);
      vt[18] = mk(0,1,1,1, 1,1,1,0,0);
      vt[19] = mk(0,1,1,1, 1,1,1,0,0);
      vt[20] = mk(0,1,1,1, 0,1,1,3,0);
      vt[21] = mk(1,1,1,1, 1,1,1,0,0);
      vt[22] = mk(1,1,1,1, 1,1,1,0,0);
      vt[23] = mk(1,1,1,1, 1,1,0,0,0);
      vt[24] = mk(1,0,1,0, 1,1,1,0,0);
      vt[25] = mk(1,0,1,0, 1,1,1,0,0);
      vt[26] = mk(1,0,1,0, 1,1,1,0,0);
      vt[27] = mk(1,0,1,0, 1,1,1,0,0);
      vt[28] = mk(1,0,1,0, 1,1,1,0,0);
      vt[29] = mk(1,0,1,1, 1,1,1,0,0);
      vt[30] = mk(1,0,1,1, 1,1,1,0,0);
      vt[31] = mk(1,0,1,1, 0,1,1,1,0);
      vt[32] = mk(1,1,1,1, 1,1,1,0,0);
      vt[33] = mk(1,1,1,1, 1,1,1,0,0);
      vt[34] = mk(1,1,1,1, 1,1,0,0,0);
      vt[35] = mk(1,1,0,1, 1,1,1,0,0);
      vt[36] = mk(1,1,0,1, 1,1,1,0,0);
      vt[37] = mk(1,1,1,1, 1,1,1,0,0);
      vt[38] = mk(1,1,1,1, 1,1,0,0,0);
      vt[39] = mk(1,1,1,1, 1,1,0,0,0);
      vt[40] = mk(0,0,0,1, 1,1,1,0,0);
      vt[41] = mk(0,0,0,1, 1,1,1,0,0);
      vt[42] = mk(0,0,0,1, 1,1,1,0,0);
      vt[43] = mk(0,0,0,1, 0,1,1,1,0);
      vt[44] = mk(0,1,0,1, 1,1,1,0,0);
      vt[45] = mk(0,1,0,1, 1,1,1,0,0);
      vt[46] = mk(0,1,0,1, 1,1,0,0,0);
      vt[47] = mk(0,1,0,1, 1,1,1,0,0);
      vt[48] = mk(0,1,0,1, 1,1,1,0,0);
      vt[49] = mk(0,1,0,1, 1,1,1,0,0);
      vt[50] = mk(0,1,0,1, 1,0,1,2,0);
      vt[51] = mk(1,1,1,1, 1,1,1,0,0);
      vt[52] = mk(1,1,1,1, 1,1,1,0,0);
      vt[53] = mk(1,1,1,1, 1,1,0,0,0);

      xresetil = 1'b0;
      xdbrl_0  = 1'b1;
      xdbrl_1  = 1'b1;
      gpu_brl  = 1'b1;
      bus_idle = 1'b1;
      #12;
      chk("reset_outs", outs(), 6'b110000);
      xresetil = 1'b1;

      for (int i = 0; i < NV; i++) begin
         xdbrl_0  = vt[i].r0;
         xdbrl_1  = vt[i].r1;
         gpu_brl  = vt[i].g;
         bus_idle = vt[i].bi;
         step();
         chk($sformatf("vec%0d", i), outs(),
             {26'd0, vt[i].xd, vt[i].gb, vt[i].h, vt[i].own, vt[i].err});
      end

      // Watchdog: GPU hogs the bus
      low = 0; errs = 0; grants = 0; err_ok = 1; prev = 1'b1;
      gpu_brl = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!gpu_bgl) low++;
         if (prev && !gpu_bgl) grants++;
         if (hold_err) begin
            errs++;
            if (!(prev == 1'b0 && gpu_bgl == 1'b1)) err_ok = 0;
         end
         prev = gpu_bgl;
      end
      chk("hog_low_cycles", low, 8);
      chk("hog_err_pulses", errs, 1);
      chk("hog_err_at_release", err_ok, 1);
      chk("hog_no_regrant", grants, 1);
      chk("hog_cpu_free", int'(cpu_hold), 0);

      // Releasing the request clears the mask; next request is served
      gpu_brl = 1'b1;
      step();
      gpu_brl = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (gpu_bgl && n < 10);
      chk("unmask_grant_lat", n, 4);
      chk("unmask_outs", outs(), 6'b101100);
      gpu_brl = 1'b1;
      step();
      step();
      step();
      chk("unmask_idle", outs(), 6'b110000);

      // Async reset while Jerry holds the bus
      xdbrl_1 = 1'b0;
      step();
      step();
      step();
      step();
      chk("pre_reset_grant", outs(), 6'b011010);
      #3;
      xresetil = 1'b0;
      #1;
      chk("async_reset_outs", outs(), 6'b110000);
      xdbrl_1 = 1'b1;
      #10;
      xresetil = 1'b1;
      step();
      chk("post_reset_idle", outs(), 6'b110000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
